div_unit: RTL

- Iterative radix-2 restoring divider for MIPS DIV/DIVU. It sits beside the combinational ALU in the execute stage and consumes the same rs/rt operand pair.
- It produces quotient (to LO) and remainder (to HI) after a fixed 33-cycle latency.
- The execute stage stalls on busy and captures results on the done pulse.
- Exception flush aborts an in-flight divide via cancel.

---
 rtl/mips_defs.sv | 16 +
 rtl/div_step.sv | 27 ++
 rtl/div_unit.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/mips_defs.sv
// Shared MIPS execute-stage definitions: divider FSM encoding, default datapath
// width, and the DIV/DIVU funct codes the decoder maps onto div_signed.
package mips_defs;

    localparam int DIV_WIDTH = 32;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_CALC = 2'd1,
        DIV_FIX  = 2'd2
    } div_state_e;

    localparam logic [5:0] FUNCT_DIV  = 6'h1a;
    localparam logic [5:0] FUNCT_DIVU = 6'h1b;

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift the next dividend bit into the partial
// remainder, then subtract the divisor if it fits.
module div_step
    import mips_defs::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic [WIDTH-1:0] rem_in,
    input  logic             bit_in,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_out,
    output logic             q_bit
);

    logic [WIDTH:0]   shifted;
    logic [WIDTH-1:0] diff;

    // Compare at WIDTH+1 bits; only the low bits of the difference are kept,
    // which is exact because a taken subtraction always leaves rem < divisor.
    always_comb begin
        shifted = {rem_in, bit_in};
        diff    = shifted[WIDTH-1:0] - divisor;
        q_bit   = (shifted >= {1'b0, divisor});
        rem_out = q_bit ? diff : shifted[WIDTH-1:0];
    end

endmodule

// File: rtl/div_unit.sv
// Iterative radix-2 restoring divider for MIPS DIV/DIVU: quotient to LO,
// remainder to HI, fixed 33-cycle latency, abortable by cancel.
module div_unit
    import mips_defs::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             div_start,
    input  logic             div_signed,
    input  logic             cancel,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);

    localparam int              CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    div_state_e       state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [WIDTH-1:0] dvd_q, dvd_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] a_raw_q, a_raw_d;
    logic             neg_quo_q, neg_quo_d;
    logic             neg_rem_q, neg_rem_d;
    logic             dbz_q, dbz_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] quotient_q, quotient_d;
    logic [WIDTH-1:0] remainder_q, remainder_d;

    logic [WIDTH-1:0] step_rem;
    logic             step_bit;
    logic             accept;

    assign accept = (state_q == DIV_IDLE) && div_start && !cancel;

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem_in  (rem_q),
        .bit_in  (dvd_q[WIDTH-1]),
        .divisor (dvs_q),
        .rem_out (step_rem),
        .q_bit   (step_bit)
    );

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q     <= DIV_IDLE;
            count_q     <= '0;
            dvd_q       <= '0;
            dvs_q       <= '0;
            rem_q       <= '0;
            a_raw_q     <= '0;
            neg_quo_q   <= 1'b0;
            neg_rem_q   <= 1'b0;
            dbz_q       <= 1'b0;
            done_q      <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            dvd_q       <= dvd_d;
            dvs_q       <= dvs_d;
            rem_q       <= rem_d;
            a_raw_q     <= a_raw_d;
            neg_quo_q   <= neg_quo_d;
            neg_rem_q   <= neg_rem_d;
            dbz_q       <= dbz_d;
            done_q      <= done_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            DIV_IDLE: if (accept) state_d = DIV_CALC;
            DIV_CALC: begin
                if (cancel)                  state_d = DIV_IDLE;
                else if (count_q == LAST_CNT) state_d = DIV_FIX;
            end
            DIV_FIX:  state_d = DIV_IDLE;
            default:  state_d = DIV_IDLE;
        endcase
    end

    always_comb begin
        busy      = (state_q != DIV_IDLE);
        done      = done_q;
        quotient  = quotient_q;
        remainder = remainder_q;
    end

    // The dividend register doubles as the quotient: each iteration shifts a
    // dividend bit out of the top and the new quotient bit in at the bottom.
    always_comb begin
        count_d     = count_q;
        dvd_d       = dvd_q;
        dvs_d       = dvs_q;
        rem_d       = rem_q;
        a_raw_d     = a_raw_q;
        neg_quo_d   = neg_quo_q;
        neg_rem_d   = neg_rem_q;
        dbz_d       = dbz_q;
        done_d      = 1'b0;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        if (accept) begin
            dvd_d     = (div_signed && a[WIDTH-1]) ? -a : a;
            dvs_d     = (div_signed && b[WIDTH-1]) ? -b : b;
            a_raw_d   = a;
            neg_quo_d = div_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
            neg_rem_d = div_signed && a[WIDTH-1];
            dbz_d     = (b == '0);
            rem_d     = '0;
            count_d   = '0;
        end else if (state_q == DIV_CALC && !cancel) begin
            rem_d   = step_rem;
            dvd_d   = {dvd_q[WIDTH-2:0], step_bit};
            count_d = count_q + CNT_W'(1);
        end else if (state_q == DIV_FIX && !cancel) begin
            done_d = 1'b1;
            // Divide-by-zero reports the raw dividend and bypasses the sign fix.
            if (dbz_q) begin
                quotient_d  = '1;
                remainder_d = a_raw_q;
            end else begin
                quotient_d  = neg_quo_q ? -dvd_q : dvd_q;
                remainder_d = neg_rem_q ? -rem_q : rem_q;
            end
        end
    end

endmodule
